alu_issue_stage: RTL and testbench

Upstream issue/writeback stage for the 8-bit combinational ALU (A, B, opcode -> out).
- Buffers commands in a small FIFO.
- Registers one command at a time onto the ALU operand/opcode lines.
- Captures the ALU result one cycle later, with zero and negative flags, and presents it on a valid/ready result port.
- Keeps an accumulator so a command can take operand A from the previous result.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 81 ++++++++
 rtl/alu_issue_stage.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default datapath widths, the ALU opcode encodings and the command
// record that travels through the command FIFO.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_AND  = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_OR   = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_NOR  = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_NAND = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_PASS = 3'b111;

    // One queued ALU command. use_acc replaces a with the accumulator at issue.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [ALU_OPW-1:0]   op;
        logic                 use_acc;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Latency: written entry visible at the head the cycle after the push (no bypass).
// Backpressure: full_o high when DEPTH entries held; pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (pointers and count only)
//   push_i, wr_dat_i    write strobe and data
//   pop_i               remove the head entry
//   rd_dat_o            head entry (meaningless while empty_o)
//   full_o, empty_o     occupancy flags
//   count_o             number of entries held, 0..DEPTH
module alu_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            wr_dat_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rd_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational ALU: FIFO -> issue register -> result register, with accumulator.
// Latency: push at cycle N on an idle pipe -> alu_* at N+2 -> res_valid at N+3; 1 result/cycle, dependent ops 1 per 2 cycles.
// Backpressure: res_ready low freezes result and issue registers; FIFO fills and cmd_ready (= !full) drops.
//
// Optional build macro: ALU_CARRY_EN adds res_carry (carry for ADD, borrow for SUB, else 0).
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake; cmd_a, cmd_b, cmd_op, cmd_use_acc payload
//   acc_clr                            synchronous accumulator clear (wins over a capture)
//   alu_a, alu_b, alu_op               registered operands to the ALU; alu_out its combinational result
//   res_valid/res_ready                result handshake; res_data, res_zero, res_neg (res_carry) payload
//   fifo_count                         command FIFO occupancy
// WIDTH and OPW must equal the package widths, which size the command record.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [OPW-1:0]           cmd_op,
    input  logic                     cmd_use_acc,
    input  logic                     acc_clr,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OPW-1:0]           alu_op,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_zero,
    output logic                     res_neg,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_CARRY_EN
    ,
    output logic                     res_carry
`endif
);

    alu_cmd_t push_cmd;
    alu_cmd_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;

    logic     advance;
    logic     hazard;
    logic     load;
    logic     capture;

    logic             iss_vld_q, iss_vld_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;

    logic             res_vld_q, res_vld_d;
    logic [WIDTH-1:0] res_dat_q, res_dat_d;
    logic             res_zero_q, res_zero_d;
    logic             res_neg_q, res_neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op, use_acc: cmd_use_acc};
    assign fifo_push = cmd_valid && cmd_ready;
    assign cmd_ready = !fifo_full;

    alu_cmd_fifo #(
        .DW    ($bits(alu_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (fifo_push),
        .wr_dat_i (push_cmd),
        .pop_i    (load),
        .rd_dat_o (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    // The result register can take a new value when empty or being drained.
    assign advance = !res_vld_q || res_ready;
    // An accumulator consumer cannot issue behind an op that has not yet
    // written the accumulator; it waits for that op to be captured.
    assign hazard  = head.use_acc && iss_vld_q;
    assign load    = !fifo_empty && (!iss_vld_q || advance) && !hazard;
    assign capture = iss_vld_q && advance;

    always_comb begin
        iss_vld_d  = iss_vld_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_vld_d  = res_vld_q;
        res_dat_d  = res_dat_q;
        res_zero_d = res_zero_q;
        res_neg_d  = res_neg_q;
        acc_d      = acc_q;

        if (load) begin
            iss_vld_d = 1'b1;
            alu_a_d   = head.use_acc ? acc_q : head.a;
            alu_b_d   = head.b;
            alu_op_d  = head.op;
        end else if (capture) begin
            iss_vld_d = 1'b0;
        end

        if (capture) begin
            res_vld_d  = 1'b1;
            res_dat_d  = alu_out;
            res_zero_d = (alu_out == '0);
            res_neg_d  = alu_out[WIDTH-1];
            acc_d      = alu_out;
        end else if (res_ready) begin
            res_vld_d  = 1'b0;
        end

        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_q  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_vld_q  <= 1'b0;
            res_dat_q  <= '0;
            res_zero_q <= 1'b0;
            res_neg_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_vld_q  <= res_vld_d;
            res_dat_q  <= res_dat_d;
            res_zero_q <= res_zero_d;
            res_neg_q  <= res_neg_d;
            acc_q      <= acc_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_vld_q;
    assign res_data  = res_dat_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;

`ifdef ALU_CARRY_EN
    // Carry/borrow is derived from the registered operands, which are the
    // exact values the ALU is computing on in the capture cycle.
    logic [WIDTH:0] sum_ext;
    logic           carry_q, carry_d;

    assign sum_ext = {1'b0, alu_a_q} + {1'b0, alu_b_q};

    always_comb begin
        carry_d = carry_q;
        if (capture) begin
            case (alu_op_q)
                OP_ADD:  carry_d = sum_ext[WIDTH];
                OP_SUB:  carry_d = (alu_a_q < alu_b_q);
                default: carry_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign res_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU on alu_out.
// Latency: n/a.
// Backpressure: exercised through res_ready and a full command FIFO.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic             cmd_use_acc;
    logic             acc_clr;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_neg;
    logic [2:0]       fifo_count;
`ifdef ALU_CARRY_EN
    logic             res_carry;
`endif

    alu_issue_stage #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_use_acc (cmd_use_acc),
        .acc_clr     (acc_clr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_neg     (res_neg),
        .fifo_count  (fifo_count)
`ifdef ALU_CARRY_EN
        ,
        .res_carry   (res_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       carry;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] m_acc;
    logic [7:0] bp_a  [6];
    logic [7:0] bp_b  [6];
    logic [2:0] bp_op [6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a | b);
            3'b110:  return ~(a & b);
            default: return a;
        endcase
    endfunction

`ifdef ALU_CARRY_EN
    function automatic logic ref_carry(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (op == 3'b000) return s[8];
        if (op == 3'b001) return (a < b);
        return 1'b0;
    endfunction
`endif

    // Environment ALU driving the DUT's result input.
    always_comb alu_out = ref_alu(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ua);
        int         budget;
        logic [7:0] ea;
        exp_t       e;
        budget      = 0;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        cmd_use_acc = ua;
        while (!cmd_ready && budget < 100) begin
            step();
            budget++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'(cmd_ready), 32'(1));
            cmd_valid = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
        ea     = ua ? m_acc : a;
        e.data = ref_alu(ea, b, op);
`ifdef ALU_CARRY_EN
        e.carry = ref_carry(ea, b, op);
`else
        e.carry = 1'b0;
`endif
        m_acc = e.data;
        sb.push_back(e);
    endtask

    task automatic wait_res(input string tag);
        int budget;
        budget = 0;
        while (!res_valid && budget < 50) begin
            step();
            budget++;
        end
        chk({tag, "_wait"}, 32'(res_valid), 32'(1));
    endtask

    // Scoreboard: every presented result is compared with the oldest expected
    // entry; it is retired only when the consumer accepts it, so held results
    // are re-checked for stability each cycle.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                assert (sb.size() != 0) n_pass++;
                else $error("FAIL unexpected_result: observed data 0x%0h with no expected entry", res_data);
            end else begin
                chk("sb_res_data", 32'(res_data), 32'(sb[0].data));
                chk("sb_res_zero", 32'(res_zero), 32'(sb[0].data == 8'h00));
                chk("sb_res_neg",  32'(res_neg),  32'(sb[0].data[7]));
`ifdef ALU_CARRY_EN
                chk("sb_res_carry", 32'(res_carry), 32'(sb[0].carry));
`endif
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int         budget;
        int         k;
        int         t [3];
        logic [7:0] d [3];

        bp_a  = '{8'h10, 8'h50, 8'hF0, 8'h0F, 8'h55, 8'hC3};
        bp_b  = '{8'h20, 8'h20, 8'h0F, 8'h0F, 8'hAA, 8'hFF};
        bp_op = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOR, OP_NAND};

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_op      = '0;
        cmd_use_acc = 1'b0;
        acc_clr     = 1'b0;
        res_ready   = 1'b1;
        m_acc       = 8'h00;

        // Power-on reset state.
        repeat (2) step();
        chk("por_fifo_count", 32'(fifo_count), 32'(0));
        chk("por_cmd_ready",  32'(cmd_ready),  32'(1));
        chk("por_res_valid",  32'(res_valid),  32'(0));
        chk("por_alu_a",      32'(alu_a),      32'(0));
        #2 rst_n = 1'b1;
        step();

        // Single ADD with exact latency.
        push(8'h05, 8'h03, OP_ADD, 1'b0);
        chk("add_fifo_count", 32'(fifo_count), 32'(1));
        chk("add_alu_a_early", 32'(alu_a), 32'(0));
        step();
        chk("add_alu_a",  32'(alu_a),  32'(8'h05));
        chk("add_alu_b",  32'(alu_b),  32'(8'h03));
        chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("add_res_valid_early", 32'(res_valid), 32'(0));
        step();
        chk("add_res_valid", 32'(res_valid), 32'(1));
        chk("add_res_data",  32'(res_data),  32'(8'h08));
        chk("add_res_zero",  32'(res_zero),  32'(0));
        chk("add_res_neg",   32'(res_neg),   32'(0));

        // Wrap-around and flags.
        push(8'h03, 8'h05, OP_SUB, 1'b0);
        wait_res("sub");
        chk("sub_res_data", 32'(res_data), 32'(8'hFE));
        chk("sub_res_neg",  32'(res_neg),  32'(1));
        chk("sub_res_zero", 32'(res_zero), 32'(0));
`ifdef ALU_CARRY_EN
        chk("sub_res_carry", 32'(res_carry), 32'(1));
`endif
        push(8'hAA, 8'hAA, OP_XOR, 1'b0);
        wait_res("xor");
        chk("xor_res_data", 32'(res_data), 32'(8'h00));
        chk("xor_res_zero", 32'(res_zero), 32'(1));
        chk("xor_res_neg",  32'(res_neg),  32'(0));
        repeat (3) step();

        // Backpressure until the FIFO is full.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(bp_a[i], bp_b[i], bp_op[i], 1'b0);
        step();
        chk("bp_cmd_ready",  32'(cmd_ready),  32'(0));
        chk("bp_fifo_count", 32'(fifo_count), 32'(DEPTH));
        chk("bp_res_valid",  32'(res_valid),  32'(1));
        cmd_valid = 1'b1;
        cmd_a     = 8'h77;
        cmd_b     = 8'h01;
        cmd_op    = OP_ADD;
        repeat (3) step();
        chk("bp_no_push_when_full", 32'(fifo_count), 32'(DEPTH));
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 60) begin
            step();
            budget++;
        end
        chk("bp_drain_left", 32'(sb.size()), 32'(0));
        chk("bp_cmd_ready_after", 32'(cmd_ready), 32'(1));

        // Dependent accumulator chain.
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        m_acc   = 8'h00;
        for (int i = 0; i < 3; i++) push(8'hEE, 8'h01, OP_ADD, 1'b1);
        k = 0;
        budget = 0;
        while (k < 3 && budget < 40) begin
            if (res_valid) begin
                t[k] = cyc;
                d[k] = res_data;
                k++;
            end
            step();
            budget++;
        end
        chk("acc_results_seen", 32'(k), 32'(3));
        chk("acc_res0", 32'(d[0]), 32'(8'h01));
        chk("acc_res1", 32'(d[1]), 32'(8'h02));
        chk("acc_res2", 32'(d[2]), 32'(8'h03));
        chk("acc_gap01", 32'(t[1] - t[0]), 32'(2));
        chk("acc_gap12", 32'(t[2] - t[1]), 32'(2));
        repeat (2) step();

        // Accumulator clear in the same cycle as a capture.
        push(8'h10, 8'h00, OP_ADD, 1'b0);
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("clr_cap_res_valid", 32'(res_valid), 32'(1));
        chk("clr_cap_res_data",  32'(res_data),  32'(8'h10));
        m_acc = 8'h00;
        push(8'hEE, 8'h01, OP_ADD, 1'b1);
        wait_res("clr_next");
        chk("clr_next_res_data", 32'(res_data), 32'(8'h01));
        repeat (2) step();

        // Reset in the middle of traffic with three commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i + 1), 8'h10, OP_ADD, 1'b0);
        chk("mid_fifo_count_before", 32'(fifo_count), 32'(3));
        rst_n = 1'b0;
        #1;
        chk("mid_fifo_count", 32'(fifo_count), 32'(0));
        chk("mid_cmd_ready",  32'(cmd_ready),  32'(1));
        chk("mid_res_valid",  32'(res_valid),  32'(0));
        chk("mid_res_data",   32'(res_data),   32'(0));
        chk("mid_res_zero",   32'(res_zero),   32'(0));
        chk("mid_res_neg",    32'(res_neg),    32'(0));
        chk("mid_alu_a",      32'(alu_a),      32'(0));
        chk("mid_alu_b",      32'(alu_b),      32'(0));
        chk("mid_alu_op",     32'(alu_op),     32'(0));
`ifdef ALU_CARRY_EN
        chk("mid_res_carry",  32'(res_carry),  32'(0));
`endif
        sb.delete();
        m_acc = 8'h00;
        step();
        res_ready = 1'b1;
        #2 rst_n = 1'b1;
        repeat (5) step();
        chk("post_rst_res_valid", 32'(res_valid), 32'(0));
        push(8'hEE, 8'h05, OP_ADD, 1'b1);
        wait_res("post_rst_acc");
        chk("post_rst_acc_res", 32'(res_data), 32'(8'h05));
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
